// File: rtl/jk_pkg.sv
// Shared JK stage command encoding for the JK-based modulo counter.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SET    = 2'd1,
    RST    = 2'd2,
    TOGGLE = 2'd3
  } jk_cmd_t;

  // Returns {j,k} for a stage command.
  function automatic logic [1:0] jk_to_jk(input jk_cmd_t cmd);
    logic [1:0] jk;
    jk = 2'b00;
    case (cmd)
      HOLD:    jk = 2'b00;
      SET:     jk = 2'b10;
      RST:     jk = 2'b01;
      TOGGLE:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_stage.sv
// Single JK flip-flop stage with synchronous active-low reset; qb is always ~q.
module jk_stage (
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MODULUS counter built from JK stages.
// Define JK_COUNTER_UPDOWN_EN to add the up port and down counting.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef JK_COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_b,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // Full-range counters roll over by plain toggling, so no force is needed.
  localparam bit NATURAL = (MODULUS == (1 << WIDTH));

  logic             at_max;
  logic             load_ok;
  logic [WIDTH-1:0] load_target;
  logic [WIDTH-1:0] wrap_target;
  logic             wrap_event;
  logic             wrap_force;
  logic [WIDTH-1:0] step_toggle;
  logic [WIDTH-1:0] low_ones;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  assign at_max      = (count == MAX_VAL);
  assign load_ok     = (32'(load_value) < MODULUS);
  assign load_target = load_ok ? load_value : '0;

`ifdef JK_COUNTER_UPDOWN_EN
  logic             at_zero;
  logic [WIDTH-1:0] low_zeros;

  assign at_zero     = (count == '0);
  assign wrap_event  = en && !load && (up ? at_max : at_zero);
  assign wrap_target = up ? '0 : MAX_VAL;
  assign step_toggle = up ? low_ones : low_zeros;
  assign tc          = up ? at_max : at_zero;
`else
  assign wrap_event  = en && !load && at_max;
  assign wrap_target = '0;
  assign step_toggle = low_ones;
  assign tc          = at_max;
`endif

  assign wrap_force = wrap_event && !NATURAL;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << gi) - 1);
      jk_cmd_t    cmd;
      logic [1:0] jk;

      assign low_ones[gi] = ((count & LOW_MASK) == LOW_MASK);
`ifdef JK_COUNTER_UPDOWN_EN
      assign low_zeros[gi] = ((count & LOW_MASK) == '0);
`endif

      always_comb begin
        cmd = HOLD;
        if (load) begin
          cmd = load_target[gi] ? SET : RST;
        end else if (en) begin
          if (wrap_force)            cmd = wrap_target[gi] ? SET : RST;
          else if (step_toggle[gi])  cmd = TOGGLE;
        end
      end

      assign jk = jk_to_jk(cmd);

      jk_stage u_stage (
        .clock (clock),
        .reset (reset),
        .j     (jk[1]),
        .k     (jk[0]),
        .q     (count[gi]),
        .qb    (count_b[gi])
      );
    end
  endgenerate

  always_comb begin
    wrap_d     = wrap_event;
    load_err_d = load_err_q | (load && !load_ok);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (MODULUS=10 and MODULUS=16 instances).
module tb_jk_mod_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_value;
  logic       up;
  logic [3:0] count, count_b, count16, count16_b;
  logic       tc, wrap, load_err, tc16, wrap16, load_err16;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock(clock), .reset(reset), .en(en), .load(load), .load_value(load_value),
`ifdef JK_COUNTER_UPDOWN_EN
    .up(up),
`endif
    .count(count), .count_b(count_b), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clock(clock), .reset(reset), .en(en), .load(load), .load_value(load_value),
`ifdef JK_COUNTER_UPDOWN_EN
    .up(up),
`endif
    .count(count16), .count_b(count16_b), .tc(tc16), .wrap(wrap16), .load_err(load_err16)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; load = 1'b1; load_value = 4'd5; up = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (count !== 4'd0 || count_b !== 4'hF || wrap !== 1'b0 || load_err !== 1'b0 || tc !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: count=%h count_b=%h wrap=%b err=%b tc=%b expected 0 F 0 0 0",
                 c, count, count_b, wrap, load_err, tc);
      end
    end
    reset = 1'b1; en = 1'b0; load = 1'b0;
    $display("reset: count=%h count_b=%h", count, count_b);
  endtask

  task automatic test_count();
    logic [3:0] exp_c;
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_c = 4'(k % 10);
      checks++;
      if (count !== exp_c || count_b !== ~exp_c || tc !== (exp_c == 4'd9) || wrap !== (k == 10)) begin
        errors++;
        $display("FAIL count k=%0d: count=%h count_b=%h tc=%b wrap=%b expected %h %h %b %b",
                 k, count, count_b, tc, wrap, exp_c, ~exp_c, exp_c == 4'd9, k == 10);
      end
      $display("count k=%0d: count=%0d tc=%b wrap=%b", k, count, tc, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; en = 1'b1; load_value = 4'd7;
    step();
    checks++;
    if (count !== 4'd7 || load_err !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load7: count=%h err=%b wrap=%b expected 7 0 0", count, load_err, wrap);
    end
    load_value = 4'd9;
    step();
    step();  // load at count 9 with en: no wrap pulse
    checks++;
    if (count !== 4'd9 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_at_max: count=%h wrap=%b expected 9 0", count, wrap);
    end
    load_value = 4'd12;
    step();
    checks++;
    if (count !== 4'd0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load12: count=%h err=%b expected 0 1", count, load_err);
    end
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (count !== 4'(k) || load_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky k=%0d: count=%h err=%b expected %h 1", k, count, load_err, 4'(k));
      end
    end
    en = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if (load_err !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL err_clear: err=%b count=%h expected 0 0", load_err, count);
    end
    $display("load: done, err=%b", load_err);
  endtask

  task automatic test_enable();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd4, 4'd4, 4'd5, 4'd5};
    load = 1'b1; load_value = 4'd3; en = 1'b0;
    step();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en = (k % 2 == 0);
      step();
      checks++;
      if (count !== exp_seq[k] || count_b !== ~exp_seq[k]) begin
        errors++;
        $display("FAIL enable k=%0d: count=%h count_b=%h expected %h %h",
                 k, count, count_b, exp_seq[k], ~exp_seq[k]);
      end
      $display("enable k=%0d: en=%b count=%0d", k, en, count);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_wrap();
    load = 1'b1; load_value = 4'd9;
    step();
    load = 1'b0; en = 1'b1; reset = 1'b0;
    step();
    reset = 1'b1; en = 1'b0;
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wrap: count=%h wrap=%b expected 0 0", count, wrap);
    end
    $display("reset_mid_wrap: count=%0d wrap=%b", count, wrap);
  endtask

`ifdef JK_COUNTER_UPDOWN_EN
  task automatic test_down();
    logic [3:0] exp_c [3];
    logic       exp_tc [3];
    logic       exp_w [3];
    exp_c  = '{4'd0, 4'd9, 4'd8};
    exp_tc = '{1'b1, 1'b0, 1'b0};
    exp_w  = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; load_value = 4'd1;
    step();
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (count !== exp_c[k] || tc !== exp_tc[k] || wrap !== exp_w[k] || count_b !== ~exp_c[k]) begin
        errors++;
        $display("FAIL down k=%0d: count=%h tc=%b wrap=%b expected %h %b %b",
                 k, count, tc, wrap, exp_c[k], exp_tc[k], exp_w[k]);
      end
      $display("down k=%0d: count=%0d tc=%b wrap=%b", k, count, tc, wrap);
    end
    en = 1'b0; up = 1'b1;
  endtask
`endif

  task automatic test_mod16();
    load = 1'b1; load_value = 4'd15; en = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (count16 !== 4'hF || tc16 !== 1'b1) begin
      errors++;
      $display("FAIL mod16_load: count=%h tc=%b expected F 1", count16, tc16);
    end
    en = 1'b1;
    step();
    checks++;
    if (count16 !== 4'h0 || wrap16 !== 1'b1 || count16_b !== 4'hF || tc16 !== 1'b0) begin
      errors++;
      $display("FAIL mod16_wrap: count=%h wrap=%b count_b=%h tc=%b expected 0 1 F 0",
               count16, wrap16, count16_b, tc16);
    end
    step();
    checks++;
    if (count16 !== 4'h1 || wrap16 !== 1'b0) begin
      errors++;
      $display("FAIL mod16_after: count=%h wrap=%b expected 1 0", count16, wrap16);
    end
    en = 1'b0;
    $display("mod16: count=%0d wrap=%b", count16, wrap16);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; load_value = 4'd0; up = 1'b1;
    #1;
    test_reset();
    test_count();
    test_load();
    test_enable();
    test_reset_mid_wrap();
`ifdef JK_COUNTER_UPDOWN_EN
    test_down();
`endif
    test_mod16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
